// File: rtl/program_memory_pkg.sv
// Shared types and constants for the 4-bit CPU program store.
// Optional feature macro: PROG_MEM_CHECKSUM_EN (adds the CHECK state).
package program_memory_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } prog_state_e;

    // Running program checksum: plain 8-bit sum, wraps modulo 256.
    function automatic data_t checksum_add(input data_t acc, input data_t b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x WORD_W register file: synchronous write, synchronous clear,
// asynchronous (combinational) read.
module prog_mem_array
    import program_memory_pkg::*;
#(
    parameter int DEPTH  = PROG_DEPTH,
    parameter int WORD_W = DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Storage update: clear wins over write so reset always wipes the program.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WORD_W{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_memory.sv
// Instruction store and byte-stream loader for the 4-bit CPU.
// Holds the CPU in reset (cpu_run=0) while a program is being loaded.
// Optional feature macro: PROG_MEM_CHECKSUM_EN -- a trailing checksum byte
// is compared against the modulo-256 sum of the program bytes.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int DEPTH  = PROG_DEPTH,
    parameter int WORD_W = DATA_W
) (
    input  logic        clock,
    input  logic        reset,
    input  addr_t       addr,
    output data_t       data,
    output logic        cpu_run,
    input  logic        load_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic [4:0]  load_count,
    output logic        load_error
);

    localparam addr_t ADDR_LAST = addr_t'(DEPTH - 1);

    prog_state_e state_q, state_d;
    addr_t       ptr_q, ptr_d;
    logic [4:0]  count_q, count_d;
    logic        run_q;
    logic        ready_q;
    logic        hs_s;
    logic        we_s;
    data_t       rdata_s;
`ifdef PROG_MEM_CHECKSUM_EN
    data_t       sum_q, sum_d;
    logic        err_q, err_d;
`endif

    // The handshake uses the registered ready, so valid never reaches ready.
    assign hs_s = load_valid & ready_q;

    prog_mem_array #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_array (
        .clk_i   (clock),
        .clr_i   (~reset),
        .we_i    (we_s),
        .waddr_i (ptr_q),
        .wdata_i (load_data),
        .raddr_i (addr),
        .rdata_o (rdata_s)
    );

    // State and datapath registers; reset returns to an empty, halted store.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= HALT;
            ptr_q   <= 4'd0;
            count_q <= 5'd0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            run_q   <= (state_d == RUN);
            ready_q <= (state_d == LOAD) || (state_d == CHECK);
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state decision: restart beats a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT, RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (hs_s && (load_last || (ptr_q == ADDR_LAST))) begin
`ifdef PROG_MEM_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
            CHECK: begin
`ifdef PROG_MEM_CHECKSUM_EN
                if (load_start) begin
                    state_d = LOAD;
                end else if (hs_s) begin
                    state_d = (load_data == sum_q) ? RUN : HALT;
                end else begin
                    state_d = CHECK;
                end
`else
                state_d = HALT;
`endif
            end
            default: state_d = HALT;
        endcase
    end

    // Datapath controls: memory write, pointer/count/checksum updates.
    always_comb begin
        we_s    = 1'b0;
        ptr_d   = ptr_q;
        count_d = count_q;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            HALT, RUN, CHECK: begin
                if (load_start) begin
                    ptr_d   = 4'd0;
                    count_d = 5'd0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = 8'd0;
                    err_d   = 1'b0;
                end else if ((state_q == CHECK) && hs_s && (load_data != sum_q)) begin
                    err_d   = 1'b1;
`endif
                end else begin
                    ptr_d   = ptr_q;
                end
            end
            LOAD: begin
                if (load_start) begin
                    ptr_d   = 4'd0;
                    count_d = 5'd0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end else if (hs_s) begin
                    we_s    = 1'b1;
                    ptr_d   = ptr_q + 4'd1;
                    count_d = count_q + 5'd1;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = checksum_add(sum_q, load_data);
`endif
                end else begin
                    we_s    = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Fetch port is blanked while a program is in flight.
    always_comb begin
        if ((state_q == LOAD) || (state_q == CHECK)) begin
            data = 8'h00;
        end else begin
            data = rdata_s;
        end
    end

    assign cpu_run    = run_q;
    assign load_ready = ready_q;
    assign load_count = count_q;
`ifdef PROG_MEM_CHECKSUM_EN
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_memory.sv
// Randomised self-checking bench for program_memory with a transaction-level
// reference model (program image array plus load progress bookkeeping).
module tb_program_memory;
    import program_memory_pkg::*;

`ifdef PROG_MEM_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    addr_t       addr;
    data_t       data;
    logic        cpu_run;
    logic        load_start;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        load_last;
    logic [4:0]  load_count;
    logic        load_error;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic [7:0] m_mem [16];
    bit m_loading, m_checking, m_running, m_err;
    int m_ptr, m_count, m_sum;

    always #5 clock = ~clock;

    program_memory dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .cpu_run    (cpu_run),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_count (load_count),
        .load_error (load_error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit rst_n, input bit start, input bit valid,
                                       input logic [7:0] b, input bit last);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_loading = 0; m_checking = 0; m_running = 0; m_err = 0;
            m_ptr = 0; m_count = 0; m_sum = 0;
        end else if (m_loading || m_checking) begin
            if (start) begin
                m_loading = 1; m_checking = 0; m_ptr = 0; m_count = 0; m_sum = 0;
            end else if (valid && m_loading) begin
                m_mem[m_ptr] = b;
                m_count++;
                m_sum = (m_sum + b) % 256;
                m_ptr = (m_ptr + 1) % 16;
                if (last || m_count == 16) begin
                    m_loading = 0;
                    if (CK) m_checking = 1;
                    else    m_running  = 1;
                end
            end else if (valid && m_checking) begin
                m_checking = 0;
                if (int'(b) == m_sum) m_running = 1;
                else                  m_err = 1;
            end
        end else if (start) begin
            m_loading = 1; m_running = 0; m_err = 0;
            m_ptr = 0; m_count = 0; m_sum = 0;
        end
    endfunction

    function automatic logic [7:0] exp_data(input int a);
        return (m_loading || m_checking) ? 8'h00 : m_mem[a];
    endfunction

    task automatic check_outputs();
        addr = addr_t'($urandom_range(0, 15));
        #1;
        check_val("data", data, exp_data(int'(addr)));
        check_val("cpu_run", cpu_run, m_running);
        check_val("load_ready", load_ready, m_loading || m_checking);
        check_val("load_count", load_count, m_count);
        check_val("load_error", load_error, m_err);
    endtask

    task automatic step(input bit rst_n, input bit start, input bit valid,
                        input logic [7:0] b, input bit last);
        reset = rst_n; load_start = start; load_valid = valid;
        load_data = b; load_last = last;
        @(posedge clock);
        model_edge(rst_n, start, valid, b, last);
        #1;
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'($urandom);
        check_outputs();
    endtask

    task automatic check_all_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = addr_t'(i);
            #1;
            check_val(tag, data, exp_data(i));
        end
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b0; addr = 4'd0; load_start = 1'b0; load_valid = 1'b0;
        load_data = 8'h00; load_last = 1'b0;

        // reset state
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check_all_mem("reset_mem");
        check_val("reset_run", cpu_run, 1'b0);

        // short load 31/52/F0
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h31, 0);
        step(1, 0, 1, 8'h52, 0);
        step(1, 0, 1, 8'hF0, 1);
        if (CK) step(1, 0, 1, 8'h73, 0);   // 31+52+F0 = 0x173 -> 0x73
        check_val("s1_count", load_count, 5'd3);
        check_val("s1_run", cpu_run, 1'b1);
        check_all_mem("s1_mem");

        // 16-byte load, valid every other cycle, no last
        step(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 8'($urandom), 0);
            step(1, 0, 0, 8'($urandom), 0);
        end
        if (CK) step(1, 0, 1, 8'(m_sum), 0);
        check_val("s2_count", load_count, 5'd16);
        check_all_mem("s2_mem");

        // restart on the 2nd byte's edge
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'hA5, 0);
        step(1, 1, 1, 8'h5A, 0);
        check_val("s3_count", load_count, 5'd0);
        step(1, 0, 1, 8'hC3, 0);
        step(1, 0, 1, 8'h3C, 1);
        if (CK) step(1, 0, 1, 8'hFF, 0);
        check_all_mem("s3_mem");

`ifdef PROG_MEM_CHECKSUM_EN
        // checksum good then bad
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h01, 0);
        step(1, 0, 1, 8'h02, 1);
        step(1, 0, 1, 8'h03, 0);
        check_val("ck_good_run", cpu_run, 1'b1);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h01, 0);
        step(1, 0, 1, 8'h02, 1);
        step(1, 0, 1, 8'h04, 0);
        check_val("ck_bad_err", load_error, 1'b1);
        check_val("ck_bad_run", cpu_run, 1'b0);
`endif

        // reset in mid-load after 5 bytes
        step(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 8'($urandom | 1), 0);
        step(0, 0, 0, 8'h00, 0);
        check_val("s5_count", load_count, 5'd0);
        check_all_mem("s5_mem");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            b = 8'($urandom);
            if (m_checking && ($urandom_range(0, 1) == 0)) b = 8'(m_sum);
            step($urandom_range(0, 79) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) != 0, b, $urandom_range(0, 5) == 0);
        end
        check_all_mem("rand_mem");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_memory.md
# program_memory

Instruction store and loader feeding the 4-bit CPU's fetch path: holds 16 × 8-bit instruction words, returns `data` combinationally for the CPU's `addr`, and accepts a new program over a valid/ready byte stream. While a load is in progress it holds the CPU in reset through `cpu_run`, then releases it so execution starts at address 0. It sits directly upstream of the CPU's `addr`/`data` pins.

## Interface
- `DEPTH`, 16: instruction words; must equal 2^width of `addr_t`.
- `WORD_W`, 8: bits per word; must equal width of `data_t`.
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `addr`  input  `addr_t`  CPU fetch address.
- `data`  output  `data_t`  instruction at `addr`; opcode[7:4], imm[3:0].
- `cpu_run`  output  1  drives CPU `reset`; 0 holds CPU in reset.
- `load_start`  input  1  one-cycle pulse; begins or restarts a load.
- `load_valid`  input  1  `load_data` valid.
- `load_ready`  output  1  block accepts a byte this cycle.
- `load_data`  input  8  program byte.
- `load_last`  input  1  qualifies the final program byte.
- `load_count`  output  5  bytes written by current/last load, 0–16.
- `load_error`  output  1  checksum mismatch; see Configuration.

## Operation
- States: HALT, LOAD, CHECK (macro only), RUN. Reset → HALT; all words cleared to 8'h00; `load_count`=0, `load_error`=0, `cpu_run`=0.
- HALT/RUN: `load_ready`=0, `load_valid` ignored. `load_start` → LOAD, write pointer=0, `load_count`=0, `load_error`=0.
- LOAD: `load_ready`=1. Handshake = `load_valid & load_ready` at the clock edge; writes `mem[ptr]`, increments ptr and `load_count`.
- Load ends on a handshake with `load_last`=1, or on the 16th handshake (ptr wraps 15→0, forced last). Next state: CHECK if macro defined, else RUN.
- Short load: words beyond the last written keep their previous contents.
- `load_start` while in LOAD/CHECK restarts: ptr=0, count=0; a same-cycle handshake byte is discarded, not written.
- `data` = `mem[addr]` combinationally in HALT and RUN; 8'h00 in LOAD/CHECK.
- `cpu_run` = 1 only in RUN.
- `reset` in mid-load: memory cleared, state HALT, partial program lost.

## Timing
- Write at the handshake edge; the new word is visible on `data` combinationally from that edge, with zero-cycle read latency.
- `cpu_run` comes from a flop and rises at the edge that accepts the final byte (or checksum), so the CPU's first executing edge is the next one, at address 0.
- `cpu_run` falls at the edge that samples `load_start`, so the CPU is reset from that edge on.
- `load_ready` is a state decode, registered and glitch-free, with no combinational path from `load_valid`.
- Back-to-back handshakes at one byte per cycle; a 16-byte load takes 16 cycles after `load_start`.

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - A running 8-bit sum of program bytes, modulo 256, is kept during LOAD.
  - After the final program byte the block enters CHECK with `load_ready`=1, and the next handshake byte is taken as the checksum; `load_last` is ignored in CHECK.
  - If the checksum equals the sum, the next state is RUN.
  - Otherwise the next state is HALT with `load_error`=1, held until the next `load_start`.
- Macro undefined: there is no CHECK state and no sum register, and `load_error` is tied to 0.

## Structure
- Shared package (alongside existing `addr_t`/`data_t`): `prog_state_e` enum (HALT, LOAD, CHECK, RUN), `PROG_DEPTH` constant.
- Sub-module `prog_mem_array`: DEPTH×WORD_W register file with synchronous write, synchronous clear and asynchronous read. The FSM, pointer, count and checksum logic stay in `program_memory`.

## Test plan
- Reset → `cpu_run`=0, `load_ready`=0, `data`=8'h00 for all 16 addresses, `load_count`=0.
- `load_start`, then bytes 8'h31, 8'h52, 8'hF0 with `load_last` on 8'hF0 → `load_count`=3, `cpu_run`=1 at the accept edge, `data` at addr 0/1/2 = 31/52/F0, addr 3 = 00.
- 16 bytes, no `load_last`, `load_valid` toggled every other cycle → exactly 16 writes, RUN after the 16th, addr 15 holds the 16th byte.
- `load_start` asserted on the edge carrying the 2nd byte of a load → that byte is not written, `load_count`=0, then a fresh load writes from addr 0.
- With macro: bytes 01, 02 (last), then checksum 03 → RUN. Repeat with checksum 04 → HALT, `load_error`=1, `cpu_run`=0.
- `reset` low during LOAD after 5 bytes → HALT, memory all 8'h00, `load_count`=0.
